// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshake and memory bus signals around mem_arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              lock0;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, busy, owner,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, busy, owner,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: round-robin on ties, with an optional lock
// hold that keeps ownership with the last winner while it keeps requesting.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock_hold,
  output logic winner,
  output logic valid
);

  // Choose a port from the live requests and the last winner.
  always_comb begin
    valid  = req0 | req1;
    winner = PORT_CPU;
    if (lock_hold && ((last == PORT_LDR) ? req1 : req0)) begin
      winner = last;
    end else if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = PORT_LDR;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-ported program/data memory.
// Each accepted request becomes exactly one three-cycle transaction:
// IDLE (arbitrate) -> ACCESS (gnt, mem_en) -> RESPOND (done, rdata).
// Optional feature macro: MEM_ARB_LOCK_EN lets the owner port keep ownership
// by holding its lock input; without it arbitration is pure round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic pick_winner;
  logic pick_valid;
  logic lock_hold;

`ifdef MEM_ARB_LOCK_EN
  assign lock_hold = (owner_q == PORT_LDR) ? bus.lock1 : bus.lock0;
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

  mem_arb_pick u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last      (owner_q),
    .lock_hold (lock_hold),
    .winner    (pick_winner),
    .valid     (pick_valid)
  );

  // Next-state and registered-output logic for the three-state transaction FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = ACCESS;
          owner_d  = pick_winner;
          mem_en_d = 1'b1;
          if (pick_winner == PORT_LDR) begin
            gnt1_d      = 1'b1;
            mem_we_d    = bus.we1;
            mem_addr_d  = bus.addr1;
            mem_wdata_d = bus.wdata1;
          end else begin
            gnt0_d      = 1'b1;
            mem_we_d    = bus.we0;
            mem_addr_d  = bus.addr0;
            mem_wdata_d = bus.wdata0;
          end
        end
      end
      ACCESS: begin
        state_d = RESPOND;
        done0_d = (owner_q == PORT_CPU);
        done1_d = (owner_q == PORT_LDR);
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= PORT_LDR;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The memory itself registers read data, so it is already aligned with
  // RESPOND; it is gated to zero whenever no done is being reported.
  assign bus.rdata     = (done0_q | done1_q) ? bus.mem_rdata : '0;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a synchronous memory model.
// Lock expectations follow MEM_ARB_LOCK_EN when the bench is built with it.
module tb_mem_arbiter;

  logic clock;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  int   tie_exp  [4];
  int   lock_exp [4];
  logic [7:0] mem [256];

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clock) begin
    if (!reset) begin
      mem[8'h12] <= 8'h5A;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [7:0] d1);
    bus.req0   = r0;
    bus.we0    = w0;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.req1   = r1;
    bus.we1    = w1;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    tie_exp = '{0, 1, 0, 1};
`ifdef MEM_ARB_LOCK_EN
    lock_exp = '{1, 1, 1, 0};
`else
    lock_exp = '{0, 1, 0, 1};
`endif
    reset     = 1'b0;
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    tick();

    // Reset values
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    checkOutput("rst_done", {bus.done0, bus.done1}, 0);
    checkOutput("rst_mem_en", bus.mem_en, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_owner", bus.owner, 1);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    reset = 1'b1;
    tick();

    // Single read from port 0
    applyStimulus(1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("rd_gnt0", bus.gnt0, 1);
    checkOutput("rd_gnt1", bus.gnt1, 0);
    checkOutput("rd_mem_en", bus.mem_en, 1);
    checkOutput("rd_mem_we", bus.mem_we, 0);
    checkOutput("rd_mem_addr", bus.mem_addr, 8'h12);
    checkOutput("rd_busy", bus.busy, 1);
    checkOutput("rd_owner", bus.owner, 0);
    tick();
    checkOutput("rd_done0", bus.done0, 1);
    checkOutput("rd_done1", bus.done1, 0);
    checkOutput("rd_gnt0_off", bus.gnt0, 0);
    checkOutput("rd_mem_en_off", bus.mem_en, 0);
    checkOutput("rd_rdata", bus.rdata, 8'h5A);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("rd_idle_busy", bus.busy, 0);
    checkOutput("rd_idle_done0", bus.done0, 0);

    // Single write from port 1, then read back via port 0
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'hC3);
    tick();
    checkOutput("wr_gnt1", bus.gnt1, 1);
    checkOutput("wr_gnt0", bus.gnt0, 0);
    checkOutput("wr_mem_we", bus.mem_we, 1);
    checkOutput("wr_mem_addr", bus.mem_addr, 8'h30);
    checkOutput("wr_mem_wdata", bus.mem_wdata, 8'hC3);
    checkOutput("wr_owner", bus.owner, 1);
    tick();
    checkOutput("wr_done1", bus.done1, 1);
    checkOutput("wr_done0", bus.done0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    applyStimulus(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("rb_gnt0", bus.gnt0, 1);
    tick();
    checkOutput("rb_done0", bus.done0, 1);
    checkOutput("rb_rdata", bus.rdata, 8'hC3);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Reset during ACCESS discards the transaction
    applyStimulus(1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("mr_gnt0", bus.gnt0, 1);
    reset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("mr_done0", bus.done0, 0);
    checkOutput("mr_gnt0_off", bus.gnt0, 0);
    checkOutput("mr_mem_en", bus.mem_en, 0);
    checkOutput("mr_busy", bus.busy, 0);
    checkOutput("mr_owner", bus.owner, 1);
    checkOutput("mr_mem_addr", bus.mem_addr, 0);
    reset = 1'b1;
    tick();
    checkOutput("mr_post_done0", bus.done0, 0);
    checkOutput("mr_post_busy", bus.busy, 0);

    // Tie with both ports requesting continuously: strict alternation from port 0
    applyStimulus(1, 0, 8'h12, 8'h00, 1, 0, 8'h30, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("tie%0d_gnt0", i), bus.gnt0, (tie_exp[i] == 0));
      checkOutput($sformatf("tie%0d_gnt1", i), bus.gnt1, (tie_exp[i] == 1));
      checkOutput($sformatf("tie%0d_addr", i), bus.mem_addr,
                  (tie_exp[i] == 0) ? 8'h12 : 8'h30);
      tick();
      checkOutput($sformatf("tie%0d_done0", i), bus.done0, (tie_exp[i] == 0));
      checkOutput($sformatf("tie%0d_done1", i), bus.done1, (tie_exp[i] == 1));
      checkOutput($sformatf("tie%0d_rdata", i), bus.rdata,
                  (tie_exp[i] == 0) ? 8'h5A : 8'hC3);
      tick();
      checkOutput($sformatf("tie%0d_idle_gnt", i), {bus.gnt0, bus.gnt1}, 0);
      checkOutput($sformatf("tie%0d_idle_busy", i), bus.busy, 0);
    end

    // Port 1 holds lock after winning; lock is dropped before the fourth arbitration
    bus.lock1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.lock1 = 1'b0;
      tick();
      checkOutput($sformatf("lock%0d_gnt0", i), bus.gnt0, (lock_exp[i] == 0));
      checkOutput($sformatf("lock%0d_gnt1", i), bus.gnt1, (lock_exp[i] == 1));
      tick();
      checkOutput($sformatf("lock%0d_done", i), {bus.done1, bus.done0},
                  (lock_exp[i] == 0) ? 2'b01 : 2'b10);
      tick();
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    // Idle hold: nothing may start without a request
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("idle%0d_mem_en", i), bus.mem_en, 0);
      checkOutput($sformatf("idle%0d_gnt", i), {bus.gnt0, bus.gnt1}, 0);
      checkOutput($sformatf("idle%0d_busy", i), bus.busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single-ported program/data memory. Port 0 is the CPU control unit's fetch/operand path; port 1 is the program loader/DMA path used to fill memory before or during execution. Requests follow a req/gnt/done handshake. The arbiter owns the memory control lines: each accepted request becomes exactly one memory access, and ties are resolved round-robin.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- req0 / req1  in  1  access request, port 0 (CPU) / port 1 (loader)
- we0 / we1  in  1  1 = write, 0 = read; held stable with req
- addr0 / addr1  in  ADDR_W  access address; held stable with req
- wdata0 / wdata1  in  DATA_W  write data; held stable with req
- lock0 / lock1  in  1  keep ownership for the next access (only with MEM_ARB_LOCK_EN)
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, memory access in progress
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata  out  DATA_W  read data; valid only while done0 or done1 is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous memory read data; valid the cycle after mem_en
- busy  out  1  high in ACCESS and RESPOND
- owner  out  1  port of the current or most recent transaction

## Operation
- FSM states: IDLE, ACCESS, RESPOND. Encoding is defined in the package.
- IDLE, no request: remain in IDLE.
- IDLE, any req high: pick a winner, register its we/addr/wdata into mem_*, set owner, go to ACCESS.
- ACCESS: always go to RESPOND.
- RESPOND: always go to IDLE. Exactly three states per transaction.
- Winner selection:
  - Only one req high: that port wins.
  - Both req high: the port that is not the last winner wins (last = owner).
  - The pointer resets so that port 0 wins the first tie.
- Requester rule:
  - Hold req, we, addr and wdata stable until done.
  - Req still high in the IDLE cycle after done is a new request.
- Writes also produce done. rdata on a write is don't-care.
- Reset values (reset low at an edge):
  - State IDLE; owner 1.
  - gnt*, done*, mem_en, mem_we, busy all 0.
  - mem_addr, mem_wdata, rdata all 0.
- Reset mid-transaction: the transaction is discarded. No done is issued. A write whose mem_en already fired is not undone.
- Only one gnt and one done are high in any cycle. mem_en never asserts outside ACCESS.

## Timing
- Cycle N: state IDLE, req sampled.
- Cycle N+1 (ACCESS): gnt_x=1, mem_en=1, mem_we/mem_addr/mem_wdata valid. All are registered outputs.
- Cycle N+2 (RESPOND): done_x=1. rdata is registered from mem_rdata and is valid in this cycle.
- Cycle N+3: IDLE; arbitration occurs again.
- Throughput: one access per 3 cycles.
- Worst-case wait for a port with the other port also requesting: 3 cycles before its own gnt (lock disabled).
- Simultaneous req0 and req1 in IDLE: exactly one gnt follows; the loser's req remains pending, no loss.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - In IDLE, if the owner port has req and lock high, it wins regardless of the other port.
  - The lock input of the non-owner port is ignored.
  - Lock never extends a single transaction; it only biases the next arbitration.
- MEM_ARB_LOCK_EN undefined:
  - lock0/lock1 ports still exist but are ignored.
  - Arbitration is pure round-robin.

## Structure
- Package mem_arb_pkg contains:
  - State typedef (IDLE/ACCESS/RESPOND).
  - Port id constants PORT_CPU=0, PORT_LDR=1.
  - Default width constants ADDR_W_DEF=8, DATA_W_DEF=8.
- One sub-module: mem_arb_pick, combinational winner select (inputs: req0, req1, last, lock qualify; output: winner, valid).
- The FSM and output registers stay in mem_arbiter.

## Test plan
- Single read: req0=1, we0=0, addr0=0x12, memory holds 0x5A -> gnt0 at N+1 with mem_en=1, mem_addr=0x12; done0 at N+2 with rdata=0x5A.
- Single write: req1=1, we1=1, addr1=0x30, wdata1=0xC3 -> gnt1 at N+1 with mem_we=1, mem_wdata=0xC3; done1 at N+2; a later port-0 read of 0x30 returns 0xC3.
- Tie and alternation: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1; one gnt every 3 cycles; never two dones in the same cycle.
- Lock (MEM_ARB_LOCK_EN): after port 1 wins, hold lock1=1 with req0 and req1 high -> port 1 wins 3 consecutive times; drop lock1 -> the next grant goes to port 0. Without the macro -> strict alternation.
- Reset mid-op: reset low during ACCESS -> next cycle all outputs are 0, state IDLE, no done; a req0 after reset gets the first tie-win.
- Idle hold: no req for 10 cycles -> mem_en, gnt* and busy stay 0.
